// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus iterative
// shift-add multiply and restoring divide, one bit per clock.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] hi,
    output logic             zf,
    output logic             dz
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [SEL_W-1:0] OP_AND = SEL_W'(4'b0000);
    localparam logic [SEL_W-1:0] OP_OR  = SEL_W'(4'b0001);
    localparam logic [SEL_W-1:0] OP_ADD = SEL_W'(4'b0010);
    localparam logic [SEL_W-1:0] OP_SUB = SEL_W'(4'b0110);
    localparam logic [SEL_W-1:0] OP_SLT = SEL_W'(4'b0111);
    localparam logic [SEL_W-1:0] OP_MUL = SEL_W'(4'b0101);
    localparam logic [SEL_W-1:0] OP_DIV = SEL_W'(4'b0100);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_isDiv;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_hi;
    logic             r_dz;

    logic             w_accept;
    logic             w_isMul;
    logic             w_isDiv;
    logic             w_divZero;
    logic             w_multi;
    logic             w_lastIter;
    logic [WIDTH-1:0] w_simpleOut;
    logic [WIDTH-1:0] w_simpleHi;
    logic [WIDTH:0]   w_mulSum;
    logic [WIDTH:0]   w_divShift;
    logic [WIDTH:0]   w_divDiff;
    logic             w_qBit;
    logic [WIDTH-1:0] w_iterAcc;
    logic [WIDTH-1:0] w_iterB;

    assign w_accept   = start && (r_state == S_IDLE);
    assign w_isMul    = (sel == OP_MUL);
    assign w_isDiv    = (sel == OP_DIV);
    assign w_divZero  = w_isDiv && (op2 == '0);
    // A zero multiplier still runs the full iteration so MUL latency never varies.
    assign w_multi    = w_isMul || (w_isDiv && !w_divZero);
    assign w_lastIter = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_nextState = w_multi ? S_CALC : S_DONE;
                end
            end
            S_CALC: begin
                if (w_lastIter) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        w_simpleOut = '0;
        w_simpleHi  = '0;
        case (sel)
            OP_AND: w_simpleOut = op1 & op2;
            OP_OR:  w_simpleOut = op1 | op2;
            OP_ADD: w_simpleOut = op1 + op2;
            OP_SUB: w_simpleOut = op1 - op2;
            OP_SLT: w_simpleOut = {{(WIDTH-1){1'b0}}, (op1 < op2)};
            OP_DIV: begin
                if (w_divZero) begin
                    w_simpleOut = '1;
                    w_simpleHi  = op1;
                end
            end
            default: begin
                w_simpleOut = '0;
                w_simpleHi  = '0;
            end
        endcase
    end

    // {r_acc, r_b} is one double-width register: product for MUL, remainder:quotient for DIV.
    always_comb begin
        w_mulSum   = {1'b0, r_acc} + (r_b[0] ? {1'b0, r_a} : '0);
        w_divShift = {r_acc, r_b[WIDTH-1]};
        w_divDiff  = w_divShift - {1'b0, r_a};
        w_qBit     = ~w_divDiff[WIDTH];
        if (r_isDiv) begin
            w_iterAcc = w_qBit ? w_divDiff[WIDTH-1:0] : w_divShift[WIDTH-1:0];
            w_iterB   = {r_b[WIDTH-2:0], w_qBit};
        end else begin
            w_iterAcc = w_mulSum[WIDTH:1];
            w_iterB   = {w_mulSum[0], r_b[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_isDiv <= 1'b0;
            r_out   <= '0;
            r_hi    <= '0;
            r_dz    <= 1'b0;
        end else if (w_accept) begin
            r_a     <= w_isDiv ? op2 : op1;
            r_b     <= w_isDiv ? op1 : op2;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_isDiv <= w_isDiv;
            if (!w_multi) begin
                r_out <= w_simpleOut;
                r_hi  <= w_simpleHi;
                r_dz  <= w_divZero;
            end
        end else if (r_state == S_CALC) begin
            r_acc <= w_iterAcc;
            r_b   <= w_iterB;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_lastIter) begin
                r_out <= w_iterB;
                r_hi  <= w_iterAcc;
                r_dz  <= 1'b0;
            end
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign out  = r_out;
    assign hi   = r_hi;
    assign zf   = (r_out == '0);
    assign dz   = r_dz;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (WIDTH=32): vector table plus directed multi-cycle
// sequences, with a scoreboard queue checked whenever done pulses.
module tb_seq_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] op1 = '0;
    logic [W-1:0] op2 = '0;
    logic [3:0]   sel = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] out;
    logic [W-1:0] hi;
    logic         zf;
    logic         dz;

    seq_alu #(.WIDTH(W), .SEL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op1(op1), .op2(op2), .sel(sel),
        .busy(busy), .done(done), .out(out), .hi(hi), .zf(zf), .dz(dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expOut;
        logic [31:0] expHi;
        logic        expDz;
        int          expLat;
    } vec_t;

    typedef struct {
        string       tag;
        logic [31:0] expOut;
        logic [31:0] expHi;
        logic        expDz;
        int          expLat;
        int          acceptCyc;
    } sb_item_t;

    sb_item_t sbQueue[$];
    int cyc = 0;
    int checkCount = 0;
    int passCount = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic vec_t mkVec(input string t, input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] o, input logic [31:0] h, input logic d, input int lat);
        vec_t v;
        v.tag = t; v.sel = s; v.a = a; v.b = b;
        v.expOut = o; v.expHi = h; v.expDz = d; v.expLat = lat;
        return v;
    endfunction

    // Reference behaviour written directly from the opcode definitions.
    function automatic vec_t model(input string t, input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        vec_t v;
        v = mkVec(t, s, a, b, 32'd0, 32'd0, 1'b0, 1);
        p = {32'd0, a} * {32'd0, b};
        case (s)
            4'b0000: v.expOut = a & b;
            4'b0001: v.expOut = a | b;
            4'b0010: v.expOut = a + b;
            4'b0110: v.expOut = a - b;
            4'b0111: v.expOut = (a < b) ? 32'd1 : 32'd0;
            4'b0101: begin v.expOut = p[31:0]; v.expHi = p[63:32]; v.expLat = 33; end
            4'b0100: begin
                if (b == 32'd0) begin
                    v.expOut = 32'hFFFF_FFFF; v.expHi = a; v.expDz = 1'b1;
                end else begin
                    v.expOut = a / b; v.expHi = a % b; v.expLat = 33;
                end
            end
            default: v.expOut = 32'd0;
        endcase
        return v;
    endfunction

    // Called on a falling edge; waits for idle, drives start for one cycle.
    task automatic applyStimulus(input vec_t v, input bit track);
        int guard;
        sb_item_t item;
        guard = 0;
        while (busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput({v.tag, ".idleWait"}, 64'(busy), 64'(0));
        sel = v.sel; op1 = v.a; op2 = v.b; start = 1'b1;
        if (track) begin
            item.tag = v.tag; item.expOut = v.expOut; item.expHi = v.expHi;
            item.expDz = v.expDz; item.expLat = v.expLat; item.acceptCyc = cyc + 1;
            sbQueue.push_back(item);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        while (sbQueue.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        checkOutput({name, ".drain"}, 64'(sbQueue.size()), 64'(0));
    endtask

    always @(negedge clk) begin
        sb_item_t item;
        if (rst_n && done) begin
            if (sbQueue.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL unexpectedDone: got done=1 at cycle %0d, expected no pending operation", cyc);
            end else begin
                item = sbQueue.pop_front();
                checkOutput({item.tag, ".out"}, 64'(out), 64'(item.expOut));
                checkOutput({item.tag, ".hi"}, 64'(hi), 64'(item.expHi));
                checkOutput({item.tag, ".zf"}, 64'(zf), 64'(item.expOut == 32'd0));
                checkOutput({item.tag, ".dz"}, 64'(dz), 64'(item.expDz));
                checkOutput({item.tag, ".latency"}, 64'(cyc - item.acceptCyc + 1), 64'(item.expLat));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[13];
        logic [3:0] selList[8];
        vec_t v;
        int busyLow;

        vecs[0]  = mkVec("addWrap",  4'b0010, 32'hFFFF_FFFF, 32'd1,          32'd0,          32'd0,          1'b0, 1);
        vecs[1]  = mkVec("and",      4'b0000, 32'hF0F0_F0F0, 32'h3C3C_3C3C,  32'h3030_3030,  32'd0,          1'b0, 1);
        vecs[2]  = mkVec("or",       4'b0001, 32'h1234_0000, 32'h0000_5678,  32'h1234_5678,  32'd0,          1'b0, 1);
        vecs[3]  = mkVec("subWrap",  4'b0110, 32'd5,         32'd7,          32'hFFFF_FFFE,  32'd0,          1'b0, 1);
        vecs[4]  = mkVec("sltFalse", 4'b0111, 32'd7,         32'd5,          32'd0,          32'd0,          1'b0, 1);
        vecs[5]  = mkVec("sltUns",   4'b0111, 32'd3,         32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 1);
        vecs[6]  = mkVec("mulHi",    4'b0101, 32'h8000_0000, 32'd4,          32'd0,          32'd2,          1'b0, 33);
        vecs[7]  = mkVec("mulMax",   4'b0101, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFE,  1'b0, 33);
        vecs[8]  = mkVec("div",      4'b0100, 32'd100,       32'd7,          32'd14,         32'd2,          1'b0, 33);
        vecs[9]  = mkVec("divZero",  4'b0100, 32'd100,       32'd0,          32'hFFFF_FFFF,  32'd100,        1'b1, 1);
        vecs[10] = mkVec("dzClear",  4'b0010, 32'd1,         32'd2,          32'd3,          32'd0,          1'b0, 1);
        vecs[11] = mkVec("undefF",   4'b1111, 32'h1234_5678, 32'h9ABC_DEF0,  32'd0,          32'd0,          1'b0, 1);
        vecs[12] = mkVec("divSmall", 4'b0100, 32'd5,         32'd9,          32'd0,          32'd5,          1'b0, 33);
        selList = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b0011};

        repeat (2) @(negedge clk);
        checkOutput("reset.busy", 64'(busy), 64'(0));
        checkOutput("reset.done", 64'(done), 64'(0));
        checkOutput("reset.out", 64'(out), 64'(0));
        checkOutput("reset.hi", 64'(hi), 64'(0));
        checkOutput("reset.zf", 64'(zf), 64'(1));
        checkOutput("reset.dz", 64'(dz), 64'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i], 1'b1);
        end
        for (int i = 0; i < 8; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            if (selList[i] == 4'b0100 && $urandom_range(0, 1) == 0) rb = rb >> 20;
            v = model($sformatf("rand%0d", i), selList[i], ra, rb);
            applyStimulus(v, 1'b1);
        end
        drain("table");

        // MUL with start pulses and input churn during CALC, then DONE/IDLE start handoff.
        applyStimulus(mkVec("mulIgnore", 4'b0101, 32'hDEAD_BEEF, 32'h10, 32'hEADB_EEF0, 32'hD, 1'b0, 33), 1'b1);
        busyLow = 0;
        for (int i = 0; i < 32; i++) begin
            if (!busy) busyLow++;
            start = (i % 2 == 0);
            sel = 4'b0010;
            op1 = $urandom;
            op2 = $urandom;
            @(negedge clk);
        end
        if (!busy) busyLow++;
        checkOutput("mulIgnore.busyLowCycles", 64'(busyLow), 64'(0));
        checkOutput("mulIgnore.doneCycle", 64'(done), 64'(1));
        start = 1'b1; sel = 4'b0000; op1 = 32'hFFFF_FFFF; op2 = 32'h0F0F_0F0F;
        @(negedge clk);
        applyStimulus(mkVec("afterDone", 4'b0010, 32'd10, 32'd20, 32'd30, 32'd0, 1'b0, 1), 1'b1);
        drain("handoff");

        // Reset in the tenth CALC cycle of a divide: no done, outputs clear at once.
        applyStimulus(mkVec("divAborted", 4'b0100, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33), 1'b0);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midReset.busy", 64'(busy), 64'(0));
        checkOutput("midReset.done", 64'(done), 64'(0));
        checkOutput("midReset.out", 64'(out), 64'(0));
        checkOutput("midReset.zf", 64'(zf), 64'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(mkVec("sltAfterReset", 4'b0111, 32'd3, 32'd5, 32'd1, 32'd0, 1'b0, 1), 1'b1);
        repeat (40) @(negedge clk);
        drain("final");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
